mix_bus_accum: RTL and testbench
================================

Name: mix_bus_accum

Overview:
Parametrised output mixing accumulator for the voice/filter datapath. It sums scaled multiplier products into N_BUS independent signed buses, for example bypass, filter and effects sends. Arithmetic is saturating, with sticky clip flags. The block also owns a valid/ready output sample register that feeds delta_sigma. It sits between mult and delta_sigma/svf and is driven by the controller's accum_en/accum_rst/bus-select strobes.

Parameters:
N_BUS, 2, number of accumulation buses (1..8)
DATA_W, 14, signed width of each bus and of the output sample
PROD_W, 40, signed width of the multiplier product input
PROD_LSB, 8, LSB of the product slice fed to the buses
SEL_W, $clog2(N_BUS) (min 1), width of bus select; derived, not overridden

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
prod_i  in  PROD_W  signed multiplier product
accum_en_i  in  1  add scaled product to selected bus this cycle
accum_rst_i  in  1  clear all buses
bus_sel_i  in  SEL_W  target bus for accum_en_i
commit_i  in  1  capture the mixed sum of all buses into the output register
out_ready_i  in  1  downstream accepts out_data_o
bus_q_o  out  N_BUS*DATA_W  registered bus values, bus k at [k*DATA_W +: DATA_W]
out_data_o  out  DATA_W  signed output sample
out_valid_o  out  1  out_data_o holds an untransferred sample
clip_o  out  N_BUS+1  sticky saturation flags; bit k = bus k, bit N_BUS = mix sum
clip_clr_i  in  1  clear all clip flags
overrun_o  out  1  sticky: an unsent sample was overwritten; cleared by clip_clr_i

Behaviour:
- Reset (async, rst_ni=0): all buses 0, out_data_o 0, out_valid_o 0, clip_o 0, overrun_o 0.
- Term: t = prod_i[PROD_W-1:PROD_LSB] (sign-preserving), saturated to DATA_W (range -2^(DATA_W-1) .. 2^(DATA_W-1)-1). This replaces the old plain truncation.
- Accumulate: with accum_en_i=1 and bus_sel_i<N_BUS, bus[sel] <= sat_DATA_W(bus[sel] + t). The add is computed at DATA_W+1 bits. The result is visible on bus_q_o the next cycle.
- bus_sel_i >= N_BUS: no bus changes and no flag is set.
- Priority: accum_rst_i beats accum_en_i. When both are high, all buses go to 0 and the product is dropped.
- Clip: clip_o[sel] is set when either the term saturation or the add saturation fires on an enabled, in-range accumulate that is not overridden by accum_rst_i.
- Mix: m = sat_DATA_W(sum of all bus_q values), computed at DATA_W+SEL_W bits. Saturation of m sets clip_o[N_BUS] on commit.
- Commit uses the registered (pre-update) bus values. It is therefore unaffected by a same-cycle accum_en_i or accum_rst_i.
- Output handshake: a transfer happens in any cycle where out_valid_o and out_ready_i are both 1.
  - commit_i, no valid: load m, valid=1 next cycle.
  - commit_i while valid with out_ready_i=1: old sample transfers, new m loads, valid stays 1, no overrun.
  - commit_i while valid with out_ready_i=0: m overwrites out_data_o, overrun_o is set, valid stays 1.
  - No commit and a transfer occurs: valid=0. out_data_o holds its last value.
- clip_clr_i clears clip_o and overrun_o. A same-cycle set event wins, so the flag reads 1.
- No internal FSM beyond the valid flag. Total latency from commit_i to out_valid_o is 1 cycle.

Decomposition:
- Package mix_pkg: constant MAX_BUS=8, and a function for the DATA_W saturation limits.
- One sub-module, sat_trunc: combinational signed saturator with parameters IN_W and OUT_W and a clip output. It is instantiated for the term, per-add and mix paths.

Test Plan (N_BUS=2, DATA_W=14, PROD_LSB=8 unless noted):
- Reset, then 2x accum_en_i with bus_sel_i=0 and prod_i=100<<8 -> bus0=200, bus1=0, clip_o=000.
- bus0=8000, accumulate prod_i=300<<8 -> bus0=8191, clip_o[0]=1. Then bus1=-8000, accumulate prod_i=-300<<8 -> bus1=-8192, clip_o[1]=1.
- prod_i=20000<<8 into bus1=0 -> term saturates, bus1=8191, clip_o[1]=1. Separately, clip_clr_i in the same cycle as a clip event -> flag stays 1.
- Mix saturation and handshake:
  - bus0=bus1=5000, commit_i with out_ready_i=0 -> next cycle out_data_o=8191, out_valid_o=1, clip_o[2]=1.
  - Second commit_i with out_ready_i=0 -> data replaced, overrun_o=1.
  - commit_i with out_ready_i=1 -> no overrun, valid stays 1.
- bus0=10, bus1=20, with accum_rst_i, accum_en_i (prod_i=5<<8) and commit_i all asserted together -> buses 0, out_data_o=30.
- N_BUS=3, bus_sel_i=3 with accum_en_i -> no bus change, no flag. Also assert rst_ni low mid-sequence with valid=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/mix_pkg.sv
// -----------------------------------------------------------------------------
// mix_pkg
// Shared constants and helpers for the output mixing accumulator.
//   MAX_BUS    : largest supported number of accumulation buses
//   SEL_W_MAX  : bus-select width needed for MAX_BUS buses
//   sat_limit  : signed saturation limit (most positive or most negative)
//                of a given width, returned sign-extended to 64 bits
// -----------------------------------------------------------------------------
package mix_pkg;

    localparam int MAX_BUS   = 8;
    localparam int SEL_W_MAX = $clog2(MAX_BUS);

    // neg=0 gives 2^(width-1)-1, neg=1 gives -2^(width-1)
    function automatic logic signed [63:0] sat_limit(input int width, input logic neg);
        logic signed [63:0] one_hot;
        one_hot = 64'sd1 <<< (width - 1);
        if (neg) begin
            return -one_hot;
        end
        return one_hot - 64'sd1;
    endfunction

endpackage

// File: rtl/sat_trunc.sv
// -----------------------------------------------------------------------------
// sat_trunc
// Combinational signed saturator from IN_W bits down to OUT_W bits.
// Ports:
//   in_i   [IN_W-1:0]  signed input value
//   out_o  [OUT_W-1:0] input clamped to the OUT_W signed range
//   clip_o             high when the input was outside the OUT_W range
// When IN_W <= OUT_W the value always fits and is simply sign-extended.
// -----------------------------------------------------------------------------
module sat_trunc
    import mix_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_o,
    output logic             clip_o
);

    generate
        if (IN_W > OUT_W) begin : g_narrow
            localparam logic signed [63:0] HI = sat_limit(OUT_W, 1'b0);
            localparam logic signed [63:0] LO = sat_limit(OUT_W, 1'b1);

            // The value fits exactly when every bit above the OUT_W sign bit
            // is a copy of the input sign bit.
            logic fits;
            assign fits = (in_i[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){in_i[IN_W-1]}});

            always_comb begin
                out_o  = in_i[OUT_W-1:0];
                clip_o = 1'b0;
                if (!fits) begin
                    clip_o = 1'b1;
                    out_o  = in_i[IN_W-1] ? LO[OUT_W-1:0] : HI[OUT_W-1:0];
                end
            end
        end else begin : g_wide
            assign out_o  = {{(OUT_W-IN_W){in_i[IN_W-1]}}, in_i};
            assign clip_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mix_bus_accum.sv
// -----------------------------------------------------------------------------
// mix_bus_accum
// Saturating multi-bus mixing accumulator with a valid/ready output register.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   prod_i [PROD_W]        signed multiplier product
//   accum_en_i             add scaled product to bus bus_sel_i
//   accum_rst_i            clear all buses (beats accum_en_i)
//   bus_sel_i [SEL_W]      target bus; values >= N_BUS are ignored
//   commit_i               load saturated sum of all buses into output
//   out_ready_i            downstream accepts out_data_o
//   bus_q_o                registered buses, bus k at [k*DATA_W +: DATA_W]
//   out_data_o [DATA_W]    signed output sample
//   out_valid_o            out_data_o holds an untransferred sample
//   clip_o [N_BUS+1]       sticky clip flags, bit N_BUS is the mix sum
//   clip_clr_i             clear clip_o and overrun_o
//   overrun_o              sticky: an unsent sample was overwritten
// -----------------------------------------------------------------------------
module mix_bus_accum
    import mix_pkg::*;
#(
    parameter  int N_BUS    = 2,
    parameter  int DATA_W   = 14,
    parameter  int PROD_W   = 40,
    parameter  int PROD_LSB = 8,
    localparam int SEL_W    = (N_BUS > 1) ? $clog2(N_BUS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [PROD_W-1:0]       prod_i,
    input  logic                    accum_en_i,
    input  logic                    accum_rst_i,
    input  logic [SEL_W-1:0]        bus_sel_i,
    input  logic                    commit_i,
    input  logic                    out_ready_i,
    output logic [N_BUS*DATA_W-1:0] bus_q_o,
    output logic [DATA_W-1:0]       out_data_o,
    output logic                    out_valid_o,
    output logic [N_BUS:0]          clip_o,
    input  logic                    clip_clr_i,
    output logic                    overrun_o
);

    localparam int TERM_W = PROD_W - PROD_LSB;
    localparam int MIX_W  = DATA_W + SEL_W;

    logic [DATA_W-1:0] bus_q [N_BUS];
    logic [DATA_W-1:0] term;
    logic              term_clip;
    logic [DATA_W-1:0] sel_bus;
    logic [DATA_W:0]   add_wide;
    logic [DATA_W-1:0] add_sat;
    logic              add_clip;
    logic [MIX_W-1:0]  mix_wide;
    logic [DATA_W-1:0] mix_sat;
    logic              mix_clip;
    logic              sel_valid;
    logic              do_acc;
    logic [N_BUS:0]    clip_set;
    logic              transfer;

    // Bits below PROD_LSB are fractional and intentionally discarded.
    generate
        if (PROD_LSB > 0) begin : g_frac
            logic unused_frac;
            assign unused_frac = ^prod_i[PROD_LSB-1:0];
        end
    endgenerate

    sat_trunc #(.IN_W(TERM_W), .OUT_W(DATA_W)) u_term_sat (
        .in_i   (prod_i[PROD_W-1:PROD_LSB]),
        .out_o  (term),
        .clip_o (term_clip)
    );

    assign sel_valid = ({1'b0, bus_sel_i} < (SEL_W+1)'(N_BUS));
    assign do_acc    = accum_en_i && !accum_rst_i && sel_valid;
    assign transfer  = out_valid_o && out_ready_i;

    // Mux out the selected bus with an explicit compare so that an
    // out-of-range select never indexes past the array.
    always_comb begin
        sel_bus = '0;
        for (int k = 0; k < N_BUS; k++) begin
            if (bus_sel_i == SEL_W'(k)) begin
                sel_bus = bus_q[k];
            end
        end
    end

    assign add_wide = {sel_bus[DATA_W-1], sel_bus} + {term[DATA_W-1], term};

    sat_trunc #(.IN_W(DATA_W+1), .OUT_W(DATA_W)) u_add_sat (
        .in_i   (add_wide),
        .out_o  (add_sat),
        .clip_o (add_clip)
    );

    // Mix uses the registered bus values, so a same-cycle accumulate or
    // clear does not leak into the committed sample.
    always_comb begin
        mix_wide = '0;
        for (int k = 0; k < N_BUS; k++) begin
            mix_wide = mix_wide + {{SEL_W{bus_q[k][DATA_W-1]}}, bus_q[k]};
        end
    end

    sat_trunc #(.IN_W(MIX_W), .OUT_W(DATA_W)) u_mix_sat (
        .in_i   (mix_wide),
        .out_o  (mix_sat),
        .clip_o (mix_clip)
    );

    always_comb begin
        clip_set = '0;
        for (int k = 0; k < N_BUS; k++) begin
            if (do_acc && (bus_sel_i == SEL_W'(k))) begin
                clip_set[k] = term_clip || add_clip;
            end
        end
        clip_set[N_BUS] = commit_i && mix_clip;
    end

    generate
        for (genvar k = 0; k < N_BUS; k++) begin : g_pack
            assign bus_q_o[k*DATA_W +: DATA_W] = bus_q[k];
        end
    endgenerate

    // Bus registers: clear has priority over accumulate.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < N_BUS; k++) begin
                bus_q[k] <= '0;
            end
        end else if (accum_rst_i) begin
            for (int k = 0; k < N_BUS; k++) begin
                bus_q[k] <= '0;
            end
        end else if (do_acc) begin
            for (int k = 0; k < N_BUS; k++) begin
                if (bus_sel_i == SEL_W'(k)) begin
                    bus_q[k] <= add_sat;
                end
            end
        end
    end

    // Output sample register and handshake. A commit always loads; the
    // old sample is lost (overrun) only if it could not transfer this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
        end else if (commit_i) begin
            out_data_o  <= mix_sat;
            out_valid_o <= 1'b1;
        end else if (transfer) begin
            out_valid_o <= 1'b0;
        end
    end

    // Sticky flags: a set event in the same cycle as a clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clip_o    <= '0;
            overrun_o <= 1'b0;
        end else begin
            clip_o    <= (clip_clr_i ? '0 : clip_o) | clip_set;
            overrun_o <= (clip_clr_i ? 1'b0 : overrun_o)
                         | (commit_i && out_valid_o && !out_ready_i);
        end
    end

endmodule

// File: tb/tb_mix_bus_accum.sv
// -----------------------------------------------------------------------------
// tb_mix_bus_accum
// Directed bench for mix_bus_accum: a 2-bus instance for the main features
// and a 3-bus instance for out-of-range select and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mix_bus_accum;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;

    logic [39:0] prod_i = '0;
    logic        accum_en_i = 1'b0;
    logic        accum_rst_i = 1'b0;
    logic        bus_sel_i = 1'b0;
    logic        commit_i = 1'b0;
    logic        out_ready_i = 1'b0;
    logic        clip_clr_i = 1'b0;
    logic [27:0] bus_q_o;
    logic [13:0] out_data_o;
    logic        out_valid_o;
    logic [2:0]  clip_o;
    logic        overrun_o;

    logic [39:0] prod3 = '0;
    logic        accum_en3 = 1'b0;
    logic [1:0]  bus_sel3 = '0;
    logic        commit3 = 1'b0;
    logic [41:0] bus_q3;
    logic [13:0] out_data3;
    logic        out_valid3;
    logic [3:0]  clip3;
    logic        overrun3;

    int vec_count  = 0;
    int miss_count = 0;

    always #5 clk_i = ~clk_i;

    mix_bus_accum #(.N_BUS(2), .DATA_W(14), .PROD_W(40), .PROD_LSB(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .prod_i      (prod_i),
        .accum_en_i  (accum_en_i),
        .accum_rst_i (accum_rst_i),
        .bus_sel_i   (bus_sel_i),
        .commit_i    (commit_i),
        .out_ready_i (out_ready_i),
        .bus_q_o     (bus_q_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .clip_o      (clip_o),
        .clip_clr_i  (clip_clr_i),
        .overrun_o   (overrun_o)
    );

    mix_bus_accum #(.N_BUS(3), .DATA_W(14), .PROD_W(40), .PROD_LSB(8)) dut3 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .prod_i      (prod3),
        .accum_en_i  (accum_en3),
        .accum_rst_i (1'b0),
        .bus_sel_i   (bus_sel3),
        .commit_i    (commit3),
        .out_ready_i (1'b0),
        .bus_q_o     (bus_q3),
        .out_data_o  (out_data3),
        .out_valid_o (out_valid3),
        .clip_o      (clip3),
        .clip_clr_i  (1'b0),
        .overrun_o   (overrun3)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One accumulate of value<<8 into a bus of the 2-bus instance.
    task automatic acc(input logic sel, input longint value);
        accum_en_i = 1'b1;
        bus_sel_i  = sel;
        prod_i     = 40'(value * 256);
        tick();
        accum_en_i = 1'b0;
        prod_i     = '0;
    endtask

    task automatic clear_buses();
        accum_rst_i = 1'b1;
        tick();
        accum_rst_i = 1'b0;
    endtask

    task automatic clear_flags();
        clip_clr_i = 1'b1;
        tick();
        clip_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        vec_count++;
        if (bus_q_o !== 28'd0 || out_valid_o !== 1'b0 || out_data_o !== 14'd0
            || clip_o !== 3'b000 || overrun_o !== 1'b0) begin
            miss_count++;
            $display("[TB] FAIL reset_state: bus=%h data=%h valid=%b clip=%b ovr=%b, want all 0",
                     bus_q_o, out_data_o, out_valid_o, clip_o, overrun_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_accumulate();
        acc(1'b0, 100);
        acc(1'b0, 100);
        vec_count++;
        if (bus_q_o[13:0] !== 14'd200 || bus_q_o[27:14] !== 14'd0) begin
            miss_count++;
            $display("[TB] FAIL accum_basic: bus0=%0d bus1=%0d, want 200 0",
                     $signed(bus_q_o[13:0]), $signed(bus_q_o[27:14]));
        end
        vec_count++;
        if (clip_o !== 3'b000) begin
            miss_count++;
            $display("[TB] FAIL accum_clip: clip=%b, want 000", clip_o);
        end
    endtask

    task automatic test_bus_saturation();
        clear_buses();
        acc(1'b0, 8000);
        acc(1'b0, 300);
        vec_count++;
        if (bus_q_o[13:0] !== 14'(8191) || clip_o !== 3'b001) begin
            miss_count++;
            $display("[TB] FAIL pos_sat: bus0=%0d clip=%b, want 8191 001",
                     $signed(bus_q_o[13:0]), clip_o);
        end
        acc(1'b1, -8000);
        acc(1'b1, -300);
        vec_count++;
        if (bus_q_o[27:14] !== 14'(-8192) || clip_o !== 3'b011) begin
            miss_count++;
            $display("[TB] FAIL neg_sat: bus1=%0d clip=%b, want -8192 011",
                     $signed(bus_q_o[27:14]), clip_o);
        end
        clear_flags();
        vec_count++;
        if (clip_o !== 3'b000) begin
            miss_count++;
            $display("[TB] FAIL clip_clear: clip=%b, want 000", clip_o);
        end
    endtask

    task automatic test_term_saturation();
        clear_buses();
        acc(1'b1, 20000);
        vec_count++;
        if (bus_q_o[27:14] !== 14'(8191) || bus_q_o[13:0] !== 14'd0 || clip_o !== 3'b010) begin
            miss_count++;
            $display("[TB] FAIL term_sat: bus1=%0d bus0=%0d clip=%b, want 8191 0 010",
                     $signed(bus_q_o[27:14]), $signed(bus_q_o[13:0]), clip_o);
        end
        clear_flags();
        // Clear and a fresh add clip in the same cycle: set wins.
        clip_clr_i = 1'b1;
        acc(1'b1, 1);
        clip_clr_i = 1'b0;
        vec_count++;
        if (clip_o !== 3'b010 || bus_q_o[27:14] !== 14'(8191)) begin
            miss_count++;
            $display("[TB] FAIL clr_vs_set: clip=%b bus1=%0d, want 010 8191",
                     clip_o, $signed(bus_q_o[27:14]));
        end
        clear_flags();
    endtask

    task automatic test_mix_handshake();
        clear_buses();
        acc(1'b0, 5000);
        acc(1'b1, 5000);
        out_ready_i = 1'b0;
        commit_i    = 1'b1;
        tick();
        commit_i    = 1'b0;
        vec_count++;
        if (out_data_o !== 14'(8191) || out_valid_o !== 1'b1 || clip_o !== 3'b100
            || overrun_o !== 1'b0) begin
            miss_count++;
            $display("[TB] FAIL mix_sat: data=%0d valid=%b clip=%b ovr=%b, want 8191 1 100 0",
                     $signed(out_data_o), out_valid_o, clip_o, overrun_o);
        end
        acc(1'b0, -5000);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        vec_count++;
        if (out_data_o !== 14'(5000) || out_valid_o !== 1'b1 || overrun_o !== 1'b1) begin
            miss_count++;
            $display("[TB] FAIL overrun: data=%0d valid=%b ovr=%b, want 5000 1 1",
                     $signed(out_data_o), out_valid_o, overrun_o);
        end
        clear_flags();
        acc(1'b0, 100);
        out_ready_i = 1'b1;
        commit_i    = 1'b1;
        tick();
        commit_i    = 1'b0;
        vec_count++;
        if (out_data_o !== 14'(5100) || out_valid_o !== 1'b1 || overrun_o !== 1'b0
            || clip_o !== 3'b000) begin
            miss_count++;
            $display("[TB] FAIL commit_ready: data=%0d valid=%b ovr=%b clip=%b, want 5100 1 0 000",
                     $signed(out_data_o), out_valid_o, overrun_o, clip_o);
        end
        tick();
        vec_count++;
        if (out_valid_o !== 1'b0 || out_data_o !== 14'(5100)) begin
            miss_count++;
            $display("[TB] FAIL drain: valid=%b data=%0d, want 0 5100",
                     out_valid_o, $signed(out_data_o));
        end
        out_ready_i = 1'b0;
    endtask

    task automatic test_priority();
        clear_buses();
        acc(1'b0, 10);
        acc(1'b1, 20);
        accum_rst_i = 1'b1;
        accum_en_i  = 1'b1;
        bus_sel_i   = 1'b0;
        prod_i      = 40'(5 * 256);
        commit_i    = 1'b1;
        tick();
        accum_rst_i = 1'b0;
        accum_en_i  = 1'b0;
        prod_i      = '0;
        commit_i    = 1'b0;
        vec_count++;
        if (bus_q_o !== 28'd0 || out_data_o !== 14'd30 || out_valid_o !== 1'b1) begin
            miss_count++;
            $display("[TB] FAIL rst_priority: bus=%h data=%0d valid=%b, want 0 30 1",
                     bus_q_o, $signed(out_data_o), out_valid_o);
        end
    endtask

    task automatic test_bad_select();
        accum_en3 = 1'b1;
        bus_sel3  = 2'd0;
        prod3     = 40'(7 * 256);
        tick();
        bus_sel3  = 2'd3;
        prod3     = 40'(50 * 256);
        tick();
        bus_sel3  = 2'd2;
        prod3     = 40'(4 * 256);
        tick();
        accum_en3 = 1'b0;
        prod3     = '0;
        vec_count++;
        if (bus_q3 !== {14'd4, 14'd0, 14'd7} || clip3 !== 4'b0000) begin
            miss_count++;
            $display("[TB] FAIL bad_select: bus=%h clip=%b, want %h 0000",
                     bus_q3, clip3, {14'd4, 14'd0, 14'd7});
        end
        commit3 = 1'b1;
        tick();
        commit3 = 1'b0;
        vec_count++;
        if (out_data3 !== 14'd11 || out_valid3 !== 1'b1 || overrun3 !== 1'b0) begin
            miss_count++;
            $display("[TB] FAIL mix3: data=%0d valid=%b ovr=%b, want 11 1 0",
                     $signed(out_data3), out_valid3, overrun3);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_ni = 1'b0;
        #1;
        vec_count++;
        if (bus_q3 !== 42'd0 || out_data3 !== 14'd0 || out_valid3 !== 1'b0
            || clip3 !== 4'b0000 || overrun3 !== 1'b0
            || out_valid_o !== 1'b0 || out_data_o !== 14'd0) begin
            miss_count++;
            $display("[TB] FAIL async_reset: bus3=%h data3=%h valid3=%b data=%h valid=%b, want all 0",
                     bus_q3, out_data3, out_valid3, out_data_o, out_valid_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_bus_saturation();
        test_term_saturation();
        test_mix_handshake();
        test_priority();
        test_bad_select();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
